// File: rtl/fc_relu_argmax_seq_pkg.sv
// fc_pkg: shared FC-path types and the index-width rule
package fc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
  function automatic int idx_w(input int j);
    return (j > 1) ? $clog2(j) : 1;
  endfunction
endpackage

// File: rtl/fc_relu_argmax_seq.sv
// fc_relu_argmax_seq: serial single-comparator argmax over one ReLU vector
module fc_relu_argmax_seq
  import fc_pkg::*;
#(
  parameter int N  = 8,
  parameter int J  = 3,
  parameter int K  = 3,
  parameter int L  = 2*N+K-1,
  parameter int W  = L-1,
  parameter int IW = idx_w(J)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [J*W-1:0]  in_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IW-1:0]   out_idx,
  output logic [W-1:0]    out_max
);
  state_t         st;
  logic [J*W-1:0] vec_q;
  logic [W-1:0]   best, elem;
  logic [IW-1:0]  idx;
  logic [IW:0]    cnt;
  assign in_ready  = (st == IDLE);
  assign out_valid = (st == DONE);
  assign out_idx   = idx;
  assign out_max   = best;
  // Select the element addressed by cnt from the latched vector
  always_comb begin
    elem = '0;
    for (int r = 0; r < J; r++) elem = (cnt == (IW+1)'(r)) ? vec_q[r*W +: W] : elem;
  end
  // Accept a vector, keep the strictly-greater running max, hold result until consumed
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st    <= IDLE;
      vec_q <= '0;
      best  <= '0;
      idx   <= '0;
      cnt   <= '0;
    end else
      case (st)
        IDLE: if (in_valid) begin
          vec_q <= in_vec;
          best  <= in_vec[W-1:0];
          idx   <= '0;
          cnt   <= (IW+1)'(1);
          st    <= (J > 1) ? SCAN : DONE;
        end
        SCAN: begin
          if (elem > best) begin
            best <= elem;
            idx  <= cnt[IW-1:0];
          end
          cnt <= cnt + (IW+1)'(1);
          if (cnt == (IW+1)'(J-1)) st <= DONE;
        end
        DONE: if (out_ready) st <= IDLE;
        default: st <= IDLE;
      endcase
endmodule

// File: tb/tb_fc_relu_argmax_seq.sv
// tb_fc_relu_argmax_seq: random + directed check of J=3, J=1 and J=4 builds against a behavioural model
module tb_fc_relu_argmax_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go  = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] iv = '0, ordy = '0;
  logic [2:0] ir, ov;
  logic [2:0][67:0] vin = '0;
  logic [2:0][16:0] om;
  logic [2:0][1:0]  oi;
  int total = 0;
  int bad = 0;
  int jj [3] = '{3, 1, 4};
  fc_relu_argmax_seq #(.J(3)) u3 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_vec(vin[0][50:0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_idx(oi[0]), .out_max(om[0]));
  fc_relu_argmax_seq #(.J(1)) u1 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_vec(vin[1][16:0]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_idx(oi[1][0]), .out_max(om[1]));
  assign oi[1][1] = 1'b0;
  fc_relu_argmax_seq #(.J(4)) u4 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_vec(vin[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_idx(oi[2]), .out_max(om[2]));
  task automatic chk(input string n, input int d, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0h exp=%0h", n, d, got, exp);
    end
  endtask
  function automatic logic [16:0] am_max(input int j, input logic [67:0] v);
    logic [16:0] m = '0;
    for (int r = 0; r < j; r++) if (v[r*17 +: 17] > m) m = v[r*17 +: 17];
    return m;
  endfunction
  function automatic logic [1:0] am_idx(input int j, input logic [67:0] v);
    logic [16:0] m = am_max(j, v);
    int ix = 0;
    for (int r = j-1; r >= 0; r--) if (v[r*17 +: 17] == m) ix = r;
    return ix[1:0];
  endfunction
  int ph [3];
  int left [3];
  logic [1:0]  ei [3];
  logic [16:0] em [3];
  // Model: 0 idle, 1 scanning (left cycles remain), 2 result held
  always @(posedge clk or posedge rst)
    if (rst) for (int d = 0; d < 3; d++) ph[d] <= 0;
    else for (int d = 0; d < 3; d++)
      case (ph[d])
        0: if (iv[d]) begin
          ei[d]   <= am_idx(jj[d], vin[d]);
          em[d]   <= am_max(jj[d], vin[d]);
          ph[d]   <= (jj[d] == 1) ? 2 : 1;
          left[d] <= jj[d] - 1;
        end
        1: begin
          left[d] <= left[d] - 1;
          if (left[d] == 1) ph[d] <= 2;
        end
        default: if (ordy[d]) ph[d] <= 0;
      endcase
  // Compare every DUT against the model on each falling edge
  always @(negedge clk)
    if (go) for (int d = 0; d < 3; d++) begin
      chk("in_ready", d, 32'(ir[d]), 32'(ph[d] == 0));
      chk("out_valid", d, 32'(ov[d]), 32'(ph[d] == 2));
      if (ph[d] == 2) begin
        chk("out_idx", d, 32'(oi[d]), 32'(ei[d]));
        chk("out_max", d, 32'(om[d]), 32'(em[d]));
      end
      if (rst) begin
        chk("rst_idx", d, 32'(oi[d]), 0);
        chk("rst_max", d, 32'(om[d]), 0);
      end
    end
  task automatic run(input int d, input logic [67:0] v, input int hold,
                     output int lat, output logic [1:0] gi, output logic [16:0] gm);
    int n = 0;
    while (!ir[d] && n < 20) begin @(posedge clk); #1; n++; end
    if (!ir[d]) chk("ready_timeout", d, 0, 1);
    vin[d] = v;
    iv[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    vin[d] = {$urandom, $urandom, $urandom};
    lat = 0;
    while (!ov[d] && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!ov[d]) chk("valid_timeout", d, 0, 1);
    gi = oi[d];
    gm = om[d];
    repeat (hold) begin
      iv[d] = 1'($urandom_range(0, 1));
      vin[d] = {$urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    iv[d] = 1'b0;
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    chk("ready_after", d, 32'(ir[d]), 1);
  endtask
  initial begin
    int lat;
    logic [1:0] gi;
    logic [16:0] gm;
    logic [67:0] v;
    @(posedge clk); #1 go = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run(0, {17'd5, 17'd9, 17'd3}, 0, lat, gi, gm);
    chk("basic_idx", 0, 32'(gi), 1); chk("basic_max", 0, 32'(gm), 9); chk("basic_lat", 0, lat, 2);
    run(0, {17'd7, 17'd7, 17'd0}, 0, lat, gi, gm);
    chk("tie_idx", 0, 32'(gi), 1); chk("tie_max", 0, 32'(gm), 7);
    run(0, '0, 0, lat, gi, gm);
    chk("zero_idx", 0, 32'(gi), 0); chk("zero_max", 0, 32'(gm), 0);
    run(0, {17'h1FFFF, 17'd1, 17'd1}, 0, lat, gi, gm);
    chk("full_idx", 0, 32'(gi), 2); chk("full_max", 0, 32'(gm), 32'h1FFFF);
    run(0, {17'd5, 17'd9, 17'd3}, 10, lat, gi, gm);
    chk("bp_idx", 0, 32'(gi), 1);
    vin[0] = {17'd9, 17'd9, 17'd9};
    iv[0] = 1'b1;
    @(posedge clk); #1 iv[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1 chk("rst_valid", 0, 32'(ov[0]), 0); chk("rst_ready", 0, 32'(ir[0]), 1);
    @(posedge clk); #1 rst = 1'b0;
    run(0, {17'd1, 17'd2, 17'd3}, 0, lat, gi, gm);
    chk("post_rst_idx", 0, 32'(gi), 0); chk("post_rst_max", 0, 32'(gm), 3);
    run(1, 68'd42, 0, lat, gi, gm);
    chk("j1_idx", 1, 32'(gi), 0); chk("j1_max", 1, 32'(gm), 42); chk("j1_lat", 1, lat, 0);
    run(2, {17'd1, 17'd8, 17'd2, 17'd8}, 0, lat, gi, gm);
    chk("j4_idx", 2, 32'(gi), 0); chk("j4_max", 2, 32'(gm), 8); chk("j4_lat", 2, lat, 3);
    for (int i = 0; i < 30; i++)
      for (int d = 0; d < 3; d++) begin
        v = '0;
        for (int r = 0; r < 4; r++)
          v[r*17 +: 17] = $urandom_range(0, 1) ? 17'($urandom_range(0, 3)) : 17'($urandom);
        run(d, v, $urandom_range(0, 3), lat, gi, gm);
        chk("rand_lat", d, lat, jj[d] - 1);
      end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
